// File: rtl/wb_pkg.sv
// Shared definitions for the Wishbone burst master.
// Holds the cycle-type identifier encodings, the master FSM state type and a
// small helper that picks the CTI for the current beat.
package wb_pkg;

  // Wishbone cycle-type identifiers
  localparam logic [2:0] CtiClassic = 3'b000;
  localparam logic [2:0] CtiIncr    = 3'b010;
  localparam logic [2:0] CtiEob     = 3'b111;

  // Burst master FSM states
  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StBurst = 2'd1,
    StDone  = 2'd2,
    StAbort = 2'd3
  } wb_state_e;

  // CTI for a cycle: classic when no cycle is open, end-of-burst on the last
  // beat (single-beat bursts included), incrementing otherwise.
  function automatic logic [2:0] cti_for(input logic active, input logic last);
    logic [2:0] cti;
    cti = CtiClassic;
    if (active) begin
      cti = last ? CtiEob : CtiIncr;
    end
    return cti;
  endfunction

endpackage

// File: rtl/wb_tmo_cnt.sv
// Acknowledge-timeout counter for the Wishbone burst master.
// Ports:
//   clk    - clock, rising edge
//   rst_n  - asynchronous active-low reset
//   clr    - synchronous clear (priority over en)
//   en     - count one cycle
//   expire - high in the cycle whose increment brings the count to its
//            all-ones value, i.e. after 2^TMO_W-1 consecutive enabled cycles
module wb_tmo_cnt #(
  parameter int unsigned TMO_W = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam logic [TMO_W-1:0] CntMax = '1;
  // Expire on the edge that would make the counter reach CntMax.
  localparam logic [TMO_W-1:0] CntExp = CntMax - TMO_W'(1);

  logic [TMO_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + TMO_W'(1);
    end
  end

  assign expire = en && !clr && (cnt_q == CntExp);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/wb_burst_master.sv
// Wishbone incrementing-burst master for an SDRAM controller front end.
// Accepts a command (direction, start byte address, beat count), runs one
// Wishbone burst of 1..8 word beats, streams write data in / read data out and
// reports completion (done_o) or ack timeout (err_o) with one-cycle pulses.
// Ports:
//   sys_clk, wb_rst_n        - clock (rising edge), async active-low reset
//   sdr_init_done            - SDRAM ready; gates command acceptance only
//   cmd_vld_i/cmd_rdy_o      - command handshake
//   cmd_we_i, cmd_addr_i     - burst direction, start byte address
//   cmd_bl_i                 - beats minus one
//   wr_dat_i/wr_vld_i/wr_rdy_o - write-data stream, beat consumed on wr_rdy_o
//   rd_dat_o/rd_vld_o        - read-data stream, one cycle after each ack
//   done_o, err_o            - completion / timeout-abort pulses
//   wb_*                     - Wishbone master interface
module wb_burst_master
  import wb_pkg::*;
#(
  parameter int unsigned APP_AW = 26,
  parameter int unsigned dw     = 32,
  parameter int unsigned TMO_W  = 8
) (
  input  logic              sys_clk,
  input  logic              wb_rst_n,
  input  logic              sdr_init_done,
  input  logic              cmd_vld_i,
  output logic              cmd_rdy_o,
  input  logic              cmd_we_i,
  input  logic [APP_AW-1:0] cmd_addr_i,
  input  logic [2:0]        cmd_bl_i,
  input  logic [dw-1:0]     wr_dat_i,
  input  logic              wr_vld_i,
  output logic              wr_rdy_o,
  output logic [dw-1:0]     rd_dat_o,
  output logic              rd_vld_o,
  output logic              done_o,
  output logic              err_o,
  output logic              wb_cyc_o,
  output logic              wb_stb_o,
  output logic              wb_we_o,
  output logic [2:0]        wb_cti_o,
  output logic [APP_AW-1:0] wb_addr_o,
  output logic [dw-1:0]     wb_dat_o,
  output logic [dw/8-1:0]   wb_sel_o,
  input  logic              wb_ack_i,
  input  logic [dw-1:0]     wb_dat_i
);

  // Word-aligned addressing: low two byte-address bits are always zero.
  localparam logic [APP_AW-1:0] AddrMask = ~APP_AW'(3);
  localparam logic [APP_AW-1:0] AddrStep = APP_AW'(4);

  wb_state_e         state_q, state_d;
  logic              we_q, we_d;
  logic [APP_AW-1:0] addr_q, addr_d;
  logic [2:0]        beats_q, beats_d;  // remaining beats minus one
  logic              rd_vld_q;
  logic [dw-1:0]     rd_dat_q;

  logic in_burst;
  logic stb;
  logic beat_ack;
  logic last_beat;
  logic cmd_acc;
  logic tmo_clr;
  logic tmo_en;
  logic tmo_expire;

  assign in_burst  = (state_q == StBurst);
  // Writes stall the bus (stb low) while no write data is offered.
  assign stb       = in_burst && (we_q ? wr_vld_i : 1'b1);
  // Acks seen while stb is low do not complete a beat.
  assign beat_ack  = stb && wb_ack_i;
  assign last_beat = (beats_q == 3'd0);
  assign cmd_acc   = cmd_vld_i && cmd_rdy_o;

  // Timer only runs while a strobe is outstanding without an ack; outside a
  // burst stb is low, so it is held clear there too.
  assign tmo_clr = !stb || wb_ack_i;
  assign tmo_en  = stb && !wb_ack_i;

  wb_tmo_cnt #(
    .TMO_W (TMO_W)
  ) u_tmo_cnt (
    .clk    (sys_clk),
    .rst_n  (wb_rst_n),
    .clr    (tmo_clr),
    .en     (tmo_en),
    .expire (tmo_expire)
  );

  // Next-state logic
  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    addr_d  = addr_q;
    beats_d = beats_q;
    unique case (state_q)
      StIdle: begin
        if (cmd_acc) begin
          state_d = StBurst;
          we_d    = cmd_we_i;
          addr_d  = cmd_addr_i & AddrMask;
          beats_d = cmd_bl_i;
        end
      end
      StBurst: begin
        if (beat_ack) begin
          // Natural wrap at 2^APP_AW, no carry out.
          addr_d = addr_q + AddrStep;
          if (last_beat) begin
            state_d = StDone;
          end else begin
            beats_d = beats_q - 3'd1;
          end
        end else if (tmo_expire) begin
          state_d = StAbort;
        end
      end
      StDone, StAbort: begin
        // One cycle with cyc low before the next command can be taken.
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge sys_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      state_q <= StIdle;
      we_q    <= 1'b0;
      addr_q  <= '0;
      beats_q <= 3'd0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      beats_q <= beats_d;
    end
  end

  // Read data is registered: valid the cycle after its ack.
  always_ff @(posedge sys_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      rd_vld_q <= 1'b0;
      rd_dat_q <= '0;
    end else begin
      rd_vld_q <= beat_ack && !we_q;
      if (beat_ack && !we_q) begin
        rd_dat_q <= wb_dat_i;
      end
    end
  end

  // Outputs. The combinational pass-throughs are gated by reset so that every
  // output reads zero while reset is held, with or without a clock.
  always_comb begin
    cmd_rdy_o = wb_rst_n && (state_q == StIdle) && sdr_init_done;
    wb_cyc_o  = in_burst;
    wb_stb_o  = stb;
    wb_we_o   = in_burst && we_q;
    wb_cti_o  = cti_for(in_burst, last_beat);
    wb_addr_o = addr_q;
    wb_dat_o  = wb_rst_n ? wr_dat_i : '0;
    wb_sel_o  = {(dw/8){wb_rst_n}};
    wr_rdy_o  = beat_ack && we_q;
    rd_vld_o  = rd_vld_q;
    rd_dat_o  = rd_dat_q;
    done_o    = (state_q == StDone);
    err_o     = (state_q == StAbort);
  end

endmodule

// File: tb/tb_wb_burst_master.sv
// Self-checking bench for wb_burst_master: table-driven bursts, randomized
// bursts against a transaction-level model, and hand-written corner sequences.
module tb_wb_burst_master;

  localparam int unsigned AW = 26;
  localparam int unsigned DW = 32;
  localparam int unsigned TW = 8;
  localparam int          TmoCycles = (1 << TW) - 1;

  logic          sys_clk = 1'b0;
  logic          wb_rst_n;
  logic          sdr_init_done;
  logic          cmd_vld_i;
  logic          cmd_rdy_o;
  logic          cmd_we_i;
  logic [AW-1:0] cmd_addr_i;
  logic [2:0]    cmd_bl_i;
  logic [DW-1:0] wr_dat_i;
  logic          wr_vld_i;
  logic          wr_rdy_o;
  logic [DW-1:0] rd_dat_o;
  logic          rd_vld_o;
  logic          done_o;
  logic          err_o;
  logic          wb_cyc_o;
  logic          wb_stb_o;
  logic          wb_we_o;
  logic [2:0]    wb_cti_o;
  logic [AW-1:0] wb_addr_o;
  logic [DW-1:0] wb_dat_o;
  logic [DW/8-1:0] wb_sel_o;
  logic          wb_ack_i;
  logic [DW-1:0] wb_dat_i;

  int checks = 0;
  int errors = 0;

  always #5 sys_clk = ~sys_clk;

  wb_burst_master #(
    .APP_AW (AW),
    .dw     (DW),
    .TMO_W  (TW)
  ) dut (
    .sys_clk       (sys_clk),
    .wb_rst_n      (wb_rst_n),
    .sdr_init_done (sdr_init_done),
    .cmd_vld_i     (cmd_vld_i),
    .cmd_rdy_o     (cmd_rdy_o),
    .cmd_we_i      (cmd_we_i),
    .cmd_addr_i    (cmd_addr_i),
    .cmd_bl_i      (cmd_bl_i),
    .wr_dat_i      (wr_dat_i),
    .wr_vld_i      (wr_vld_i),
    .wr_rdy_o      (wr_rdy_o),
    .rd_dat_o      (rd_dat_o),
    .rd_vld_o      (rd_vld_o),
    .done_o        (done_o),
    .err_o         (err_o),
    .wb_cyc_o      (wb_cyc_o),
    .wb_stb_o      (wb_stb_o),
    .wb_we_o       (wb_we_o),
    .wb_cti_o      (wb_cti_o),
    .wb_addr_o     (wb_addr_o),
    .wb_dat_o      (wb_dat_o),
    .wb_sel_o      (wb_sel_o),
    .wb_ack_i      (wb_ack_i),
    .wb_dat_i      (wb_dat_i)
  );

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [2:0]    bl;
    int            ack_pct;
    int            vld_pct;
    logic [AW-1:0] exp_first;
    logic [AW-1:0] exp_last;
    int            exp_beats;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_cyc"}, wb_cyc_o, 1'b0);
    check({tag, "_stb"}, wb_stb_o, 1'b0);
    check({tag, "_we"}, wb_we_o, 1'b0);
    check({tag, "_cti"}, wb_cti_o, 3'b000);
    check({tag, "_addr"}, wb_addr_o, '0);
    check({tag, "_wdat"}, wb_dat_o, '0);
    check({tag, "_sel"}, wb_sel_o, '0);
    check({tag, "_cmd_rdy"}, cmd_rdy_o, 1'b0);
    check({tag, "_wr_rdy"}, wr_rdy_o, 1'b0);
    check({tag, "_rd_vld"}, rd_vld_o, 1'b0);
    check({tag, "_done"}, done_o, 1'b0);
    check({tag, "_err"}, err_o, 1'b0);
  endtask

  task automatic idle_inputs();
    cmd_vld_i = 1'b0;
    wr_vld_i  = 1'b0;
    wb_ack_i  = 1'b0;
  endtask

  task automatic hard_reset();
    wb_rst_n = 1'b0;
    idle_inputs();
    @(negedge sys_clk);
    @(negedge sys_clk);
    wb_rst_n = 1'b1;
  endtask

  // One burst with a randomly behaving slave and write source. Expected bus
  // activity follows from the command alone: beat i goes to
  // (aligned start + 4*i) mod 2^AW, the final beat carries EOB.
  task automatic run_burst(input logic we, input logic [AW-1:0] addr, input logic [2:0] bl,
                           input int ack_pct, input int vld_pct,
                           output logic [AW-1:0] first_a, output logic [AW-1:0] last_a,
                           output int beats);
    logic [AW-1:0] base;
    logic [AW-1:0] exp_a;
    logic [DW-1:0] rd_exp;
    logic          rd_pend;
    logic          exp_stb;
    int            total;
    int            cyc_cnt;
    first_a = '0;
    last_a  = '0;
    beats   = 0;
    @(negedge sys_clk);
    sdr_init_done = 1'b1;
    cmd_vld_i  = 1'b1;
    cmd_we_i   = we;
    cmd_addr_i = addr;
    cmd_bl_i   = bl;
    wr_vld_i   = 1'b0;
    wb_ack_i   = 1'b0;
    #1;
    check("cmd_rdy_idle", cmd_rdy_o, 1'b1);
    check("cyc_idle", wb_cyc_o, 1'b0);
    base    = addr & ~AW'(3);
    total   = int'(bl) + 1;
    rd_pend = 1'b0;
    rd_exp  = '0;
    cyc_cnt = 0;
    while (beats < total && cyc_cnt < 400) begin
      @(negedge sys_clk);
      cmd_vld_i     = 1'($urandom);
      cmd_we_i      = 1'($urandom);
      cmd_addr_i    = AW'($urandom);
      sdr_init_done = 1'($urandom);
      wr_vld_i      = ($urandom_range(99) < vld_pct);
      wr_dat_i      = $urandom;
      wb_dat_i      = $urandom;
      wb_ack_i      = ($urandom_range(99) < ack_pct);
      #1;
      exp_stb = we ? wr_vld_i : 1'b1;
      exp_a   = base + AW'(4 * beats);
      check("rd_vld", rd_vld_o, rd_pend);
      if (rd_pend) check("rd_dat", rd_dat_o, rd_exp);
      check("cyc", wb_cyc_o, 1'b1);
      check("stb", wb_stb_o, exp_stb);
      check("we", wb_we_o, we);
      check("addr", wb_addr_o, exp_a);
      check("cti", wb_cti_o, (total - beats > 1) ? 3'b010 : 3'b111);
      check("sel", wb_sel_o, 4'hF);
      check("wdat", wb_dat_o, wr_dat_i);
      check("wr_rdy", wr_rdy_o, we && exp_stb && wb_ack_i);
      check("cmd_rdy_busy", cmd_rdy_o, 1'b0);
      check("done_busy", done_o, 1'b0);
      check("err_busy", err_o, 1'b0);
      rd_pend = 1'b0;
      if (exp_stb && wb_ack_i) begin
        if (beats == 0) first_a = exp_a;
        last_a = exp_a;
        beats++;
        if (!we) begin
          rd_pend = 1'b1;
          rd_exp  = wb_dat_i;
        end
      end
      cyc_cnt++;
    end
    check("burst_complete", beats, total);
    if (beats != total) begin
      hard_reset();
      return;
    end
    // Completion cycle: a pending command must not be taken here.
    @(negedge sys_clk);
    sdr_init_done = 1'b1;
    cmd_vld_i = 1'b1;
    wr_vld_i  = 1'b1;
    wb_ack_i  = 1'($urandom);
    #1;
    check("done_pulse", done_o, 1'b1);
    check("done_cyc", wb_cyc_o, 1'b0);
    check("done_stb", wb_stb_o, 1'b0);
    check("done_cti", wb_cti_o, 3'b000);
    check("done_we", wb_we_o, 1'b0);
    check("done_err", err_o, 1'b0);
    check("done_cmd_rdy", cmd_rdy_o, 1'b0);
    check("done_wr_rdy", wr_rdy_o, 1'b0);
    check("done_rd_vld", rd_vld_o, rd_pend);
    if (rd_pend) check("done_rd_dat", rd_dat_o, rd_exp);
    @(negedge sys_clk);
    #1;
    check("post_done", done_o, 1'b0);
    check("post_cyc", wb_cyc_o, 1'b0);
    check("post_cmd_rdy", cmd_rdy_o, 1'b1);
    check("post_rd_vld", rd_vld_o, 1'b0);
    idle_inputs();
  endtask

  // Write, bl=1, write data withheld for three cycles mid-burst while the
  // slave keeps acking; those acks must be ignored.
  task automatic wait_state_seq();
    bit            pv [6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    bit            pa [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    logic [AW-1:0] ea [6] = '{26'h40, 26'h44, 26'h44, 26'h44, 26'h44, 26'h44};
    int rdy_cnt;
    int low_cnt;
    rdy_cnt = 0;
    low_cnt = 0;
    @(negedge sys_clk);
    sdr_init_done = 1'b1;
    cmd_vld_i  = 1'b1;
    cmd_we_i   = 1'b1;
    cmd_addr_i = 26'h40;
    cmd_bl_i   = 3'd1;
    wr_vld_i   = 1'b0;
    wb_ack_i   = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge sys_clk);
      cmd_vld_i = 1'b0;
      wr_vld_i  = pv[i];
      wb_ack_i  = pa[i];
      wr_dat_i  = $urandom;
      #1;
      check("ws_cyc", wb_cyc_o, 1'b1);
      check("ws_stb", wb_stb_o, pv[i]);
      check("ws_addr", wb_addr_o, ea[i]);
      check("ws_cti", wb_cti_o, (i == 0) ? 3'b010 : 3'b111);
      check("ws_wr_rdy", wr_rdy_o, pv[i] & pa[i]);
      if (wr_rdy_o) rdy_cnt++;
      if (!wb_stb_o) low_cnt++;
    end
    check("ws_rdy_pulses", rdy_cnt, 2);
    check("ws_stb_low_cycles", low_cnt, 3);
    @(negedge sys_clk);
    idle_inputs();
    #1;
    check("ws_done", done_o, 1'b1);
    check("ws_done_cyc", wb_cyc_o, 1'b0);
    @(negedge sys_clk);
    #1;
    check("ws_post_done", done_o, 1'b0);
  endtask

  // Command held while the SDRAM is not ready, then released.
  task automatic init_done_seq();
    @(negedge sys_clk);
    sdr_init_done = 1'b0;
    cmd_vld_i  = 1'b1;
    cmd_we_i   = 1'b0;
    cmd_addr_i = 26'h80;
    cmd_bl_i   = 3'd0;
    wb_ack_i   = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("init_cmd_rdy", cmd_rdy_o, 1'b0);
      check("init_cyc", wb_cyc_o, 1'b0);
      @(negedge sys_clk);
    end
    sdr_init_done = 1'b1;
    #1;
    check("init_cmd_rdy_up", cmd_rdy_o, 1'b1);
    @(negedge sys_clk);
    cmd_vld_i = 1'b0;
    wb_ack_i  = 1'b1;
    wb_dat_i  = 32'hCAFE_0001;
    #1;
    check("init_cyc_up", wb_cyc_o, 1'b1);
    check("init_addr", wb_addr_o, 26'h80);
    check("init_cti", wb_cti_o, 3'b111);
    @(negedge sys_clk);
    wb_ack_i = 1'b0;
    #1;
    check("init_done", done_o, 1'b1);
    check("init_rd_vld", rd_vld_o, 1'b1);
    check("init_rd_dat", rd_dat_o, 32'hCAFE_0001);
    @(negedge sys_clk);
    #1;
    check("init_idle", wb_cyc_o, 1'b0);
  endtask

  // Slave stops acking. Timeout = TmoCycles consecutive cycles with stb high
  // and no ack; an ack or a write wait state restarts the count.
  task automatic timeout_run(input logic we, input int gap_at, input int ack_at);
    int   run;
    int   n;
    logic saw_err;
    logic saw_done;
    logic exp_stb;
    @(negedge sys_clk);
    sdr_init_done = 1'b1;
    cmd_vld_i  = 1'b1;
    cmd_we_i   = we;
    cmd_addr_i = 26'h200;
    cmd_bl_i   = 3'd1;
    wr_vld_i   = 1'b0;
    wb_ack_i   = 1'b0;
    @(negedge sys_clk);
    cmd_vld_i = 1'b0;
    run      = 0;
    n        = 0;
    saw_err  = 1'b0;
    saw_done = 1'b0;
    while (!saw_err && n < 700) begin
      wr_vld_i = (n != gap_at);
      wb_ack_i = (n == ack_at);
      exp_stb  = we ? wr_vld_i : 1'b1;
      #1;
      if (err_o) begin
        saw_err = 1'b1;
        check("tmo_err_cyc", wb_cyc_o, 1'b0);
        check("tmo_err_stb", wb_stb_o, 1'b0);
      end else begin
        check("tmo_stb", wb_stb_o, exp_stb);
        if (done_o) saw_done = 1'b1;
        if (!exp_stb || wb_ack_i) run = 0;
        else run++;
        n++;
        @(negedge sys_clk);
      end
    end
    check("tmo_err_seen", saw_err, 1'b1);
    check("tmo_run_len", run, TmoCycles);
    check("tmo_no_done", saw_done, 1'b0);
    if (!saw_err) begin
      hard_reset();
      return;
    end
    @(negedge sys_clk);
    idle_inputs();
    #1;
    check("tmo_err_one_cycle", err_o, 1'b0);
    check("tmo_done_after", done_o, 1'b0);
    check("tmo_cyc_after", wb_cyc_o, 1'b0);
    check("tmo_cmd_rdy_back", cmd_rdy_o, 1'b1);
  endtask

  // Reset asserted mid-cycle during the second beat of an 8-beat write.
  task automatic reset_mid_burst();
    logic saw;
    @(negedge sys_clk);
    sdr_init_done = 1'b1;
    cmd_vld_i  = 1'b1;
    cmd_we_i   = 1'b1;
    cmd_addr_i = 26'h300;
    cmd_bl_i   = 3'd7;
    wr_vld_i   = 1'b1;
    wr_dat_i   = 32'h1234_5678;
    wb_ack_i   = 1'b0;
    @(negedge sys_clk);
    cmd_vld_i = 1'b0;
    wb_ack_i  = 1'b1;
    #1;
    check("rm_beat1_addr", wb_addr_o, 26'h300);
    @(negedge sys_clk);
    #1;
    check("rm_beat2_addr", wb_addr_o, 26'h304);
    check("rm_beat2_cyc", wb_cyc_o, 1'b1);
    #1 wb_rst_n = 1'b0;
    #1;
    check_all_zero("rm");
    saw = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge sys_clk);
      #1;
      if (done_o || err_o) saw = 1'b1;
      check("rm_hold_cyc", wb_cyc_o, 1'b0);
    end
    check("rm_no_pulse", saw, 1'b0);
    @(negedge sys_clk);
    wb_rst_n = 1'b1;
    idle_inputs();
    #1;
    check("rm_release_rdy", cmd_rdy_o, 1'b1);
    check("rm_release_cyc", wb_cyc_o, 1'b0);
  endtask

  initial begin
    logic [AW-1:0] fa;
    logic [AW-1:0] la;
    logic [AW-1:0] base;
    logic [AW-1:0] r_addr;
    logic [2:0]    r_bl;
    logic          r_we;
    int            nb;

    vecs.push_back('{1'b0, 26'h0000100, 3'd3, 100, 100, 26'h0000100, 26'h000010C, 4});
    vecs.push_back('{1'b1, 26'h0000203, 3'd0, 100, 100, 26'h0000200, 26'h0000200, 1});
    vecs.push_back('{1'b0, 26'h3FFFFFC, 3'd1, 100, 100, 26'h3FFFFFC, 26'h0000000, 2});
    vecs.push_back('{1'b1, 26'h3FFFFF8, 3'd7, 70, 60, 26'h3FFFFF8, 26'h0000014, 8});
    vecs.push_back('{1'b0, 26'h0001235, 3'd7, 50, 100, 26'h0001234, 26'h0001250, 8});
    vecs.push_back('{1'b1, 26'h0ABCDE4, 3'd2, 100, 100, 26'h0ABCDE4, 26'h0ABCDEC, 3});

    // Reset applied before any clock edge.
    wb_rst_n      = 1'b1;
    sdr_init_done = 1'b1;
    cmd_vld_i     = 1'b1;
    cmd_we_i      = 1'b1;
    cmd_addr_i    = 26'h0000100;
    cmd_bl_i      = 3'd3;
    wr_dat_i      = 32'hA5A5_A5A5;
    wr_vld_i      = 1'b1;
    wb_ack_i      = 1'b1;
    wb_dat_i      = '0;
    #1 wb_rst_n = 1'b0;
    #1 check_all_zero("por");
    @(negedge sys_clk);
    @(negedge sys_clk);
    #1 check_all_zero("por_clk");
    @(negedge sys_clk);
    wb_rst_n = 1'b1;
    idle_inputs();

    foreach (vecs[i]) begin
      run_burst(vecs[i].we, vecs[i].addr, vecs[i].bl, vecs[i].ack_pct, vecs[i].vld_pct,
                fa, la, nb);
      check("tbl_first_addr", fa, vecs[i].exp_first);
      check("tbl_last_addr", la, vecs[i].exp_last);
      check("tbl_beats", nb, vecs[i].exp_beats);
    end

    for (int k = 0; k < 40; k++) begin
      r_we   = 1'($urandom);
      r_addr = AW'($urandom);
      r_bl   = 3'($urandom);
      run_burst(r_we, r_addr, r_bl, int'($urandom_range(100, 40)),
                int'($urandom_range(100, 40)), fa, la, nb);
      base = r_addr & ~AW'(3);
      check("rnd_first_addr", fa, base);
      check("rnd_last_addr", la, base + AW'(4 * int'(r_bl)));
      check("rnd_beats", nb, int'(r_bl) + 1);
    end

    wait_state_seq();
    init_done_seq();
    timeout_run(1'b0, -1, -1);
    timeout_run(1'b0, -1, 60);
    timeout_run(1'b1, 200, -1);
    reset_mid_burst();

    run_burst(1'b1, 26'h0000300, 3'd7, 100, 100, fa, la, nb);
    check("post_rst_first", fa, 26'h0000300);
    check("post_rst_last", la, 26'h000031C);
    check("post_rst_beats", nb, 8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
